// File: rtl/host_wr_arbiter.sv
// host_wr_arbiter: shares one AXI4 write path (AW, W, B) among ENGINE_NUM engines.
// Bursts are granted round-robin. A granted burst keeps the path until its wlast
// beat is accepted. The grant index is placed in awid, and each B response is
// returned to the engine named by bid. A count of outstanding bursts stops new
// grants once it reaches MAX_OUTSTANDING.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   e_aw*                 per-engine AW channel (engine i at slice i)
//   e_w*                  per-engine W channel
//   e_b*                  per-engine B channel
//   m_aw*, m_w*, m_b*     shared master AXI4 write channels
//   o_outstanding         bursts accepted on AW whose B has not yet returned
//   o_err_bid             sticky flag, set when a response arrives with an unmapped bid
module host_wr_arbiter #(
   parameter int unsigned ENGINE_NUM      = 8,
   parameter int unsigned ID_WIDTH        = 5,
   parameter int unsigned ADDR_WIDTH      = 64,
   parameter int unsigned DATA_WIDTH      = 512,
   parameter int unsigned MAX_OUTSTANDING = 16
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [ENGINE_NUM*ADDR_WIDTH-1:0]   e_awaddr,
   input  logic [ENGINE_NUM*8-1:0]            e_awlen,
   input  logic [ENGINE_NUM-1:0]              e_awvalid,
   output logic [ENGINE_NUM-1:0]              e_awready,
   input  logic [ENGINE_NUM*DATA_WIDTH-1:0]   e_wdata,
   input  logic [ENGINE_NUM*DATA_WIDTH/8-1:0] e_wstrb,
   input  logic [ENGINE_NUM-1:0]              e_wlast,
   input  logic [ENGINE_NUM-1:0]              e_wvalid,
   output logic [ENGINE_NUM-1:0]              e_wready,
   output logic [ENGINE_NUM*2-1:0]            e_bresp,
   output logic [ENGINE_NUM-1:0]              e_bvalid,
   input  logic [ENGINE_NUM-1:0]              e_bready,
   output logic [ID_WIDTH-1:0]                m_awid,
   output logic [ADDR_WIDTH-1:0]              m_awaddr,
   output logic [7:0]                         m_awlen,
   output logic                               m_awvalid,
   input  logic                               m_awready,
   output logic [DATA_WIDTH-1:0]              m_wdata,
   output logic [DATA_WIDTH/8-1:0]            m_wstrb,
   output logic                               m_wlast,
   output logic                               m_wvalid,
   input  logic                               m_wready,
   input  logic [ID_WIDTH-1:0]                m_bid,
   input  logic [1:0]                         m_bresp,
   input  logic                               m_bvalid,
   output logic                               m_bready,
   output logic [7:0]                         o_outstanding,
   output logic                               o_err_bid
);

   localparam int unsigned IDX_W  = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;
   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [IDX_W-1:0]   grant;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   pick;
   logic               pick_vld;
   logic [IDX_W:0]     scan;
   logic [IDX_W:0]     grant_inc;
   logic [CNT_W-1:0]   outstanding;
   logic               err_bid;
   logic               can_grant;
   logic               aw_hs;
   logic               b_mapped;
   logic               b_hs;
   logic [IDX_W-1:0]   b_idx;

   logic [ADDR_WIDTH-1:0] awaddr_a [ENGINE_NUM];
   logic [7:0]            awlen_a  [ENGINE_NUM];
   logic [DATA_WIDTH-1:0] wdata_a  [ENGINE_NUM];
   logic [STRB_W-1:0]     wstrb_a  [ENGINE_NUM];

   // Split the flat per-engine buses into arrays so they can be indexed by grant.
   // Each engine also gets its share of the B channel here.
   for (genvar g = 0; g < ENGINE_NUM; g++) begin : g_eng
      assign awaddr_a[g] = e_awaddr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign awlen_a[g]  = e_awlen[g*8 +: 8];
      assign wdata_a[g]  = e_wdata[g*DATA_WIDTH +: DATA_WIDTH];
      assign wstrb_a[g]  = e_wstrb[g*STRB_W +: STRB_W];
      assign e_bvalid[g] = b_mapped && (b_idx == IDX_W'(g)) && m_bvalid;
      assign e_bresp[g*2 +: 2] = (b_mapped && (b_idx == IDX_W'(g))) ? m_bresp : 2'b00;
   end

   // Round-robin pick: the first requester at or after rr_ptr, wrapping past the last engine.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      scan     = '0;
      for (int k = 0; k < int'(ENGINE_NUM); k++) begin
         scan = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (scan >= (IDX_W+1)'(ENGINE_NUM)) begin
            scan = scan - (IDX_W+1)'(ENGINE_NUM);
         end
         if (!pick_vld && e_awvalid[scan[IDX_W-1:0]]) begin
            pick     = scan[IDX_W-1:0];
            pick_vld = 1'b1;
         end
      end
   end

   // B routing. A bid is mapped only if it is below ENGINE_NUM, which also requires its upper bits to be zero.
   assign b_idx    = m_bid[IDX_W-1:0];
   assign b_mapped = ({1'b0, m_bid} < (ID_WIDTH+1)'(ENGINE_NUM));
   assign m_bready = b_mapped ? e_bready[b_idx] : 1'b1;
   assign b_hs     = b_mapped && m_bvalid && m_bready;

   assign can_grant = pick_vld && (outstanding < CNT_W'(MAX_OUTSTANDING));
   assign aw_hs     = (state == ADDR) && m_awready;
   assign grant_inc = {1'b0, grant} + (IDX_W+1)'(1);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (can_grant) state_nxt = ADDR;
         ADDR: if (m_awready) state_nxt = DATA;
         DATA: if (e_wvalid[grant] && e_wlast[grant] && m_wready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Grant, round-robin pointer, outstanding counter and sticky bid error
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grant       <= '0;
         rr_ptr      <= '0;
         outstanding <= '0;
         err_bid     <= 1'b0;
      end else begin
         if (state == IDLE && can_grant) begin
            grant <= pick;
         end
         if (state == DATA && e_wvalid[grant] && e_wlast[grant] && m_wready) begin
            rr_ptr <= (grant_inc == (IDX_W+1)'(ENGINE_NUM)) ? '0 : grant_inc[IDX_W-1:0];
         end
         // If an AW handshake and a B handshake happen in the same cycle, they cancel.
         if (aw_hs && !b_hs && outstanding < CNT_W'(MAX_OUTSTANDING)) begin
            outstanding <= outstanding + CNT_W'(1);
         end else if (b_hs && !aw_hs && outstanding != '0) begin
            outstanding <= outstanding - CNT_W'(1);
         end
         if (m_bvalid && !b_mapped) begin
            err_bid <= 1'b1;
         end
      end
   end

   assign o_outstanding = outstanding;
   assign o_err_bid     = err_bid;

   // Output logic: connect the granted engine to the master channel of the current phase
   always_comb begin
      m_awid    = '0;
      m_awaddr  = '0;
      m_awlen   = '0;
      m_awvalid = 1'b0;
      m_wdata   = '0;
      m_wstrb   = '0;
      m_wlast   = 1'b0;
      m_wvalid  = 1'b0;
      e_awready = '0;
      e_wready  = '0;
      case (state)
         ADDR: begin
            m_awid           = ID_WIDTH'(grant);
            m_awaddr         = awaddr_a[grant];
            m_awlen          = awlen_a[grant];
            m_awvalid        = 1'b1;
            e_awready[grant] = m_awready;
         end
         DATA: begin
            m_wdata         = wdata_a[grant];
            m_wstrb         = wstrb_a[grant];
            m_wlast         = e_wlast[grant];
            m_wvalid        = e_wvalid[grant];
            e_wready[grant] = m_wready;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_host_wr_arbiter.sv
// tb_host_wr_arbiter: directed bench for host_wr_arbiter. It uses 8 engines, 32-bit
// address/data and MAX_OUTSTANDING=4. Inputs change 1 ns after each rising edge.
// Outputs are checked 1 ns later, well before the next rising edge.
module tb_host_wr_arbiter;

   localparam int unsigned N    = 8;
   localparam int unsigned IDW  = 5;
   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 32;
   localparam int unsigned SW   = DW / 8;
   localparam int unsigned MAXO = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N*AW-1:0]   e_awaddr;
   logic [N*8-1:0]    e_awlen;
   logic [N-1:0]      e_awvalid;
   logic [N-1:0]      e_awready;
   logic [N*DW-1:0]   e_wdata;
   logic [N*SW-1:0]   e_wstrb;
   logic [N-1:0]      e_wlast;
   logic [N-1:0]      e_wvalid;
   logic [N-1:0]      e_wready;
   logic [N*2-1:0]    e_bresp;
   logic [N-1:0]      e_bvalid;
   logic [N-1:0]      e_bready;
   logic [IDW-1:0]    m_awid;
   logic [AW-1:0]     m_awaddr;
   logic [7:0]        m_awlen;
   logic              m_awvalid;
   logic              m_awready;
   logic [DW-1:0]     m_wdata;
   logic [SW-1:0]     m_wstrb;
   logic              m_wlast;
   logic              m_wvalid;
   logic              m_wready;
   logic [IDW-1:0]    m_bid;
   logic [1:0]        m_bresp;
   logic              m_bvalid;
   logic              m_bready;
   logic [7:0]        o_outstanding;
   logic              o_err_bid;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   host_wr_arbiter #(
      .ENGINE_NUM     (N),
      .ID_WIDTH       (IDW),
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .e_awaddr     (e_awaddr),
      .e_awlen      (e_awlen),
      .e_awvalid    (e_awvalid),
      .e_awready    (e_awready),
      .e_wdata      (e_wdata),
      .e_wstrb      (e_wstrb),
      .e_wlast      (e_wlast),
      .e_wvalid     (e_wvalid),
      .e_wready     (e_wready),
      .e_bresp      (e_bresp),
      .e_bvalid     (e_bvalid),
      .e_bready     (e_bready),
      .m_awid       (m_awid),
      .m_awaddr     (m_awaddr),
      .m_awlen      (m_awlen),
      .m_awvalid    (m_awvalid),
      .m_awready    (m_awready),
      .m_wdata      (m_wdata),
      .m_wstrb      (m_wstrb),
      .m_wlast      (m_wlast),
      .m_wvalid     (m_wvalid),
      .m_wready     (m_wready),
      .m_bid        (m_bid),
      .m_bresp      (m_bresp),
      .m_bvalid     (m_bvalid),
      .m_bready     (m_bready),
      .o_outstanding(o_outstanding),
      .o_err_bid    (o_err_bid)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_aw(input int e, input logic [AW-1:0] a, input logic [7:0] l);
      e_awaddr[e*AW +: AW] = a;
      e_awlen[e*8 +: 8]    = l;
   endtask

   task automatic set_w(input int e, input logic [DW-1:0] d);
      e_wdata[e*DW +: DW] = d;
      e_wstrb[e*SW +: SW] = '1;
   endtask

   task automatic clear_inputs();
      e_awaddr  = '0;
      e_awlen   = '0;
      e_awvalid = '0;
      e_wdata   = '0;
      e_wstrb   = '0;
      e_wlast   = '0;
      e_wvalid  = '0;
      e_bready  = '0;
      m_awready = 1'b0;
      m_wready  = 1'b0;
      m_bid     = '0;
      m_bresp   = '0;
      m_bvalid  = 1'b0;
   endtask

   int n_aw;
   logic [IDW-1:0] last_id;

   // Count AW handshakes over a fixed window and record the awid of the last one.
   task automatic count_aw(input int cycles);
      n_aw = 0;
      for (int c = 0; c < cycles; c++) begin
         step();
         if (m_awvalid && m_awready) begin
            n_aw++;
            last_id = m_awid;
         end
      end
   endtask

   initial begin
      last_id = '0;
      rst_n = 1'b0;
      clear_inputs();
      repeat (3) step();

      // Reset state
      #1;
      chk("rst_awvalid", 64'(m_awvalid), 64'd0);
      chk("rst_wvalid", 64'(m_wvalid), 64'd0);
      chk("rst_awready", 64'(e_awready), 64'd0);
      chk("rst_wready", 64'(e_wready), 64'd0);
      chk("rst_outst", 64'(o_outstanding), 64'd0);
      chk("rst_err", 64'(o_err_bid), 64'd0);
      chk("rst_awid", 64'(m_awid), 64'd0);

      // Engine 2 alone: 4-beat burst at 0x1000
      rst_n = 1'b1;
      set_aw(2, 32'h1000, 8'd3);
      e_awvalid = 8'h04;
      m_awready = 1'b1;
      step();
      #1;
      chk("t1_awvalid", 64'(m_awvalid), 64'd1);
      chk("t1_awid", 64'(m_awid), 64'd2);
      chk("t1_awaddr", 64'(m_awaddr), 64'h1000);
      chk("t1_awlen", 64'(m_awlen), 64'd3);
      chk("t1_awready", 64'(e_awready), 64'h04);
      step();
      e_awvalid = '0;
      e_wvalid  = 8'h04;
      m_wready  = 1'b1;
      for (int b = 0; b < 4; b++) begin
         set_w(2, 32'hA0 + 32'(b));
         e_wlast = (b == 3) ? 8'h04 : 8'h00;
         #1;
         chk("t1_wvalid", 64'(m_wvalid), 64'd1);
         chk("t1_wdata", 64'(m_wdata), 64'hA0 + 64'(b));
         chk("t1_wstrb", 64'(m_wstrb), 64'hF);
         chk("t1_wlast", 64'(m_wlast), (b == 3) ? 64'd1 : 64'd0);
         chk("t1_wready", 64'(e_wready), 64'h04);
         step();
      end
      e_wvalid = '0;
      e_wlast  = '0;
      #1;
      chk("t1_done_wvalid", 64'(m_wvalid), 64'd0);
      chk("t1_done_outst", 64'(o_outstanding), 64'd1);
      // rr_ptr is now 3, so engine 4 must be chosen ahead of engine 0
      set_aw(0, 32'h0, 8'd0);
      set_aw(4, 32'h4000, 8'd0);
      e_awvalid = 8'h11;
      step();
      #1;
      chk("t1_rr_awid", 64'(m_awid), 64'd4);

      // All 8 engines, continuous one-beat bursts. A B response on bid 0 is present every cycle,
      // which cancels each AW increment and keeps the count at 0.
      rst_n = 1'b0;
      clear_inputs();
      step();
      for (int i = 0; i < int'(N); i++) begin
         set_aw(i, 32'(i) * 32'h100, 8'd0);
         set_w(i, 32'hD0 + 32'(i));
      end
      e_awvalid = '1;
      e_wvalid  = '1;
      e_wlast   = '1;
      e_bready  = '1;
      m_awready = 1'b1;
      m_wready  = 1'b1;
      m_bvalid  = 1'b1;
      m_bid     = '0;
      rst_n     = 1'b1;
      step();
      for (int g = 0; g < 9; g++) begin
         #1;
         chk("t2_awid", 64'(m_awid), 64'(g % 8));
         chk("t2_awaddr", 64'(m_awaddr), 64'(g % 8) * 64'h100);
         chk("t2_awready", 64'(e_awready), 64'd1 << (g % 8));
         step();
         #1;
         chk("t2_wvalid", 64'(m_wvalid), 64'd1);
         chk("t2_wdata", 64'(m_wdata), 64'hD0 + 64'(g % 8));
         chk("t2_wready", 64'(e_wready), 64'd1 << (g % 8));
         chk("t2_wlast", 64'(m_wlast), 64'd1);
         step();
         #1;
         chk("t2_idle_awvalid", 64'(m_awvalid), 64'd0);
         chk("t2_outst", 64'(o_outstanding), 64'd0);
         step();
      end

      // Throttle at MAX_OUTSTANDING=4 while no B responses arrive
      rst_n    = 1'b0;
      m_bvalid = 1'b0;
      e_bready = '0;
      step();
      rst_n = 1'b1;
      count_aw(24);
      chk("t3_aw_count", 64'(n_aw), 64'd4);
      chk("t3_last_id", 64'(last_id), 64'd3);
      chk("t3_outst", 64'(o_outstanding), 64'd4);
      chk("t3_stall_awvalid", 64'(m_awvalid), 64'd0);
      m_bvalid = 1'b1;
      m_bid    = 5'd1;
      e_bready = 8'h02;
      #1;
      chk("t3_bvalid", 64'(e_bvalid), 64'h02);
      chk("t3_bready", 64'(m_bready), 64'd1);
      step();
      m_bvalid = 1'b0;
      e_bready = '0;
      #1;
      chk("t3_outst_dec", 64'(o_outstanding), 64'd3);
      count_aw(24);
      chk("t3_aw_more", 64'(n_aw), 64'd1);
      chk("t3_more_id", 64'(last_id), 64'd4);
      chk("t3_outst_full", 64'(o_outstanding), 64'd4);

      // Engine 5 does not accept its response for 3 cycles
      e_awvalid = '0;
      m_bvalid  = 1'b1;
      m_bid     = 5'd5;
      m_bresp   = 2'b10;
      e_bready  = '0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("t4_bvalid", 64'(e_bvalid), 64'h20);
         chk("t4_bresp", 64'(e_bresp), 64'h0800);
         chk("t4_bready_low", 64'(m_bready), 64'd0);
         chk("t4_outst_hold", 64'(o_outstanding), 64'd4);
         step();
      end
      e_bready = 8'h20;
      #1;
      chk("t4_bready_high", 64'(m_bready), 64'd1);
      step();
      m_bvalid = 1'b0;
      m_bresp  = 2'b00;
      e_bready = '0;
      #1;
      chk("t4_outst_dec", 64'(o_outstanding), 64'd3);
      step();
      chk("t4_outst_once", 64'(o_outstanding), 64'd3);

      // AW and B handshakes in the same cycle at count 3
      set_aw(6, 32'h6000, 8'd0);
      set_w(6, 32'h66);
      e_awvalid = 8'h40;
      e_wvalid  = 8'h40;
      e_wlast   = 8'h40;
      m_awready = 1'b1;
      m_wready  = 1'b1;
      step();
      m_bvalid = 1'b1;
      m_bid    = 5'd2;
      e_bready = 8'h04;
      #1;
      chk("t5_awid", 64'(m_awid), 64'd6);
      chk("t5_awvalid", 64'(m_awvalid), 64'd1);
      chk("t5_bready", 64'(m_bready), 64'd1);
      step();
      m_bvalid  = 1'b0;
      e_bready  = '0;
      e_awvalid = '0;
      #1;
      chk("t5_outst_same", 64'(o_outstanding), 64'd3);
      chk("t5_wvalid", 64'(m_wvalid), 64'd1);
      step();
      // Unmapped bid 9
      m_bvalid = 1'b1;
      m_bid    = 5'd9;
      #1;
      chk("t5_bad_bready", 64'(m_bready), 64'd1);
      chk("t5_bad_bvalid", 64'(e_bvalid), 64'd0);
      chk("t5_err_before", 64'(o_err_bid), 64'd0);
      step();
      m_bvalid = 1'b0;
      m_bid    = '0;
      #1;
      chk("t5_err_set", 64'(o_err_bid), 64'd1);
      chk("t5_outst_keep", 64'(o_outstanding), 64'd3);

      // Reset during beat 2 of an 8-beat burst from engine 1
      set_aw(1, 32'h1100, 8'd7);
      set_w(1, 32'hBEEF);
      e_awvalid = 8'h02;
      e_wvalid  = 8'h02;
      e_wlast   = '0;
      step();
      #1;
      chk("t6_awid", 64'(m_awid), 64'd1);
      step();
      e_awvalid = '0;
      #1;
      chk("t6_beat1", 64'(m_wvalid), 64'd1);
      step();
      rst_n = 1'b0;
      step();
      #1;
      chk("t6_rst_wvalid", 64'(m_wvalid), 64'd0);
      chk("t6_rst_awvalid", 64'(m_awvalid), 64'd0);
      chk("t6_rst_outst", 64'(o_outstanding), 64'd0);
      chk("t6_rst_wready", 64'(e_wready), 64'd0);
      chk("t6_rst_err", 64'(o_err_bid), 64'd0);
      rst_n = 1'b1;
      set_aw(0, 32'h0800, 8'd0);
      e_awvalid = 8'h03;
      step();
      #1;
      chk("t6_post_awvalid", 64'(m_awvalid), 64'd1);
      chk("t6_post_awid", 64'(m_awid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/host_wr_arbiter.md
Name: host_wr_arbiter

Overview:
- Shares the single AXI4 host-memory write path (AW, W, B) among ENGINE_NUM engines inside the multi-process action framework.
- Each burst is granted round-robin and locked until its wlast beat is accepted.
- The engine index is tagged into awid, and write responses are steered back to the issuing engine by bid.
- An outstanding-write counter throttles new grants.

Parameters:
- ENGINE_NUM, 8, number of requesting engines (2..16).
- ID_WIDTH, 5, master AXI ID width; must be ≥ clog2(ENGINE_NUM).
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 512, data width.
- MAX_OUTSTANDING, 16, maximum AW-accepted bursts without B response (1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- e_awaddr  in  ENGINE_NUM*ADDR_WIDTH  per-engine burst address (engine i at slice i)
- e_awlen  in  ENGINE_NUM*8  per-engine burst length-1
- e_awvalid  in  ENGINE_NUM  per-engine AW request
- e_awready  out  ENGINE_NUM  per-engine AW accept
- e_wdata  in  ENGINE_NUM*DATA_WIDTH  per-engine write data
- e_wstrb  in  ENGINE_NUM*DATA_WIDTH/8  per-engine strobes
- e_wlast  in  ENGINE_NUM  per-engine last beat
- e_wvalid  in  ENGINE_NUM  per-engine data valid
- e_wready  out  ENGINE_NUM  per-engine data accept
- e_bresp  out  ENGINE_NUM*2  per-engine response code
- e_bvalid  out  ENGINE_NUM  per-engine response valid
- e_bready  in  ENGINE_NUM  per-engine response accept
- m_awid  out  ID_WIDTH  zero-extended granted engine index
- m_awaddr  out  ADDR_WIDTH  granted address
- m_awlen  out  8  granted length
- m_awvalid  out  1  master AW valid
- m_awready  in  1  master AW ready
- m_wdata  out  DATA_WIDTH  granted data
- m_wstrb  out  DATA_WIDTH/8  granted strobes
- m_wlast  out  1  granted last
- m_wvalid  out  1  master W valid
- m_wready  in  1  master W ready
- m_bid  in  ID_WIDTH  response ID
- m_bresp  in  2  response code
- m_bvalid  in  1  response valid
- m_bready  out  1  response ready
- o_outstanding  out  8  current outstanding-burst count
- o_err_bid  out  1  sticky flag: response received with unmapped bid

Behaviour:
- Reset:
  - State is IDLE; rr_ptr=0; grant=0; outstanding=0; o_err_bid=0.
  - m_awvalid, m_wvalid, all e_awready and e_wready are 0.
  - Master AW/W payload outputs are 0 while not in the corresponding state.
- FSM:
  - IDLE: if any e_awvalid and outstanding < MAX_OUTSTANDING, register grant = first requester at or after rr_ptr (circular), then go to ADDR. Otherwise stay in IDLE.
  - ADDR:
    - m_awvalid=1; m_awaddr/m_awlen muxed from the granted engine; m_awid={0,grant}.
    - e_awready[grant]=m_awready; all other e_awready are 0.
    - On AW handshake: outstanding+1, go to DATA.
  - DATA:
    - m_wdata/m_wstrb/m_wlast/m_wvalid muxed from the granted engine.
    - e_wready[grant]=m_wready; all other e_wready are 0.
    - On handshake with wlast=1: rr_ptr=(grant+1) mod ENGINE_NUM, go to IDLE.
- Latency: a request seen in IDLE at cycle N gives m_awvalid=1 at N+1. A fully-ready single-beat burst therefore occupies 3 cycles (IDLE, ADDR, DATA), and the next grant can be made in the IDLE cycle that follows.
- Lock: no other engine's W beats pass while a burst is in DATA. e_awvalid changes during ADDR/DATA do not alter the grant. Engines must hold their AW payload stable while valid.
- B path (combinational, independent of FSM):
  - idx = m_bid[clog2(ENGINE_NUM)-1:0].
  - Mapped bid (upper bid bits zero and idx < ENGINE_NUM): e_bvalid[idx]=m_bvalid, e_bresp[idx]=m_bresp, m_bready=e_bready[idx]; all other e_bvalid are 0.
  - Unmapped bid: m_bready=1, response is dropped, o_err_bid sets (cleared only by reset), outstanding is not decremented.
- Counter:
  - +1 on AW handshake, −1 on mapped B handshake, unchanged when both occur in the same cycle.
  - Saturates: never exceeds MAX_OUTSTANDING and never decrements below 0.
  - At MAX_OUTSTANDING, IDLE issues no grant until a B handshake occurs.
- Reset mid-operation: the current burst is abandoned. All outputs return to reset values on the next clk. Engines and master are reset together.

Test Plan:
- Engine 2 alone, awaddr=0x1000, awlen=3, 4 beats with m_wready=1 → m_awid=2 one cycle after request; exactly 4 W beats with wlast on the 4th; rr_ptr=3; o_outstanding=1.
- All 8 engines request one-beat bursts continuously from reset → grant order 0,1,…,7,0; no W beat from a non-granted engine ever appears on the master.
- MAX_OUTSTANDING=4, m_bvalid held 0 → exactly 4 AW handshakes then no further m_awvalid. A single B with bid=1 → exactly one more grant issues.
- m_bvalid with bid=5, bresp=2'b10, e_bready[5]=0 for 3 cycles → e_bvalid[5]=1 only, m_bready=0 until e_bready[5]=1; counter decrements once.
- AW handshake and mapped B handshake in the same cycle at count=3 → count stays 3. bid=9 with ENGINE_NUM=8 → m_bready=1, o_err_bid=1, count unchanged.
- Assert rst_n=0 during beat 2 of an 8-beat burst → next cycle: m_wvalid=0, m_awvalid=0, o_outstanding=0, state IDLE. After release, a new request from engine 0 is granted first.
